// File: rtl/nxn_b2_seq_multiplier.sv
// Sequential base-2 shift-and-add multiplier: 2N-bit product of two N-bit unsigned
// operands, one partial-product step per clock, with start/ready handshake and held result.
module nxn_b2_seq_multiplier #(
    parameter int N = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    output logic             ready,
    output logic             done,
    output logic [2*N-1:0]   p
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // state | meaning
    // IDLE  | waiting for first operation after reset
    // RUN   | iterating N shift-add steps
    // DONE  | product held in p, new start accepted
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [N-1:0]    a;
    logic [2*N:0]    r;
    logic [CW-1:0]   cnt;
    logic [N:0]      acc_next;
    logic [2*N:0]    r_next;

    // Add and shift combined: accumulator is N+1 bits so the sum never overflows.
    always_comb begin
        acc_next = r[0] ? (r[2*N:N] + {1'b0, a}) : r[2*N:N];
        r_next   = {1'b0, acc_next, r[N-1:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            a     <= '0;
            r     <= '0;
            cnt   <= '0;
            p     <= '0;
            done  <= 1'b0;
            ready <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a     <= x;
                        r     <= {{(N+1){1'b0}}, y};
                        cnt   <= '0;
                        done  <= 1'b0;
                        ready <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    r   <= r_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        p     <= r_next[2*N-1:0];
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
